// File: rtl/uart_tx_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_pkg
// Shared constants for the UART transmit arbiter: requester count, header
// nibble, frame length, FSM state encoding and the frame byte selector.
// ---------------------------------------------------------------------------
package uart_tx_arbiter_pkg;

  localparam int         NUM_REQ     = 4;
  localparam logic [3:0] HDR_NIBBLE  = 4'hA;
  localparam int         FRAME_BYTES = 5;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_SEND    = 2'd1;
  localparam state_t ST_WAIT_HI = 2'd2;
  localparam state_t ST_WAIT_LO = 2'd3;

  // Byte idx of a frame: header {nibble, 2'b00, id}, then the word MSB first.
  function automatic logic [7:0] frame_byte(input logic [3:0]  nib,
                                            input logic [1:0]  id,
                                            input logic [31:0] word,
                                            input logic [2:0]  idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = {nib, 2'b00, id};
      3'd1:    b = word[31:24];
      3'd2:    b = word[23:16];
      3'd3:    b = word[15:8];
      3'd4:    b = word[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter4.sv
// ---------------------------------------------------------------------------
// rr_arbiter4
// Purely combinational 4-way round-robin selector. The search starts at
// `pointer` and proceeds upward modulo 4; the first asserted request wins.
// Ports:
//   req     [3:0] request vector
//   pointer [1:0] highest-priority index for this decision
//   valid         any request present
//   id      [1:0] winning index (equals pointer when no request)
// ---------------------------------------------------------------------------
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] pointer,
  output logic       valid,
  output logic [1:0] id
);

  logic [1:0] idx;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    valid = 1'b0;
    id    = pointer;
    idx   = pointer;
    for (int k = 3; k >= 0; k--) begin
      idx = pointer + 2'(k);
      if (req[idx]) begin
        valid = 1'b1;
        id    = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Arbitrates four 32-bit word requesters onto a single byte-wide UART
// transmitter. Each granted word is sent as a 5-byte frame: a header carrying
// the requester id, then the word MSB first. Handshake with the UART is
// tx_we -> tx_busy rise -> tx_busy fall per byte.
// Ports:
//   clk        clock (16x bit rate, shared with the UART)
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester pending flag, held until acked
//   req_data   four 32-bit words, requester i at [32i+31:32i]
//   req_ack    one-hot one-cycle capture acknowledge
//   tx_we      byte write strobe to the UART
//   tx_data    byte presented with tx_we
//   tx_busy    UART busy, rises the cycle after an accepted tx_we
//   busy       high from capture until the last byte has drained
//   grant_id   id of the requester being sent; holds when idle
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int         NUM_REQ    = uart_tx_arbiter_pkg::NUM_REQ,
  parameter logic [3:0] HDR_NIBBLE = uart_tx_arbiter_pkg::HDR_NIBBLE
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ack,
  output logic                    tx_we,
  output logic [7:0]              tx_data,
  input  logic                    tx_busy,
  output logic                    busy,
  output logic [1:0]              grant_id
);

  state_t              state_q,    state_d;
  logic [1:0]          ptr_q,      ptr_d;
  logic [1:0]          id_q,       id_d;
  logic [31:0]         word_q,     word_d;
  logic [2:0]          byte_cnt_q, byte_cnt_d;
  logic                busy_q,     busy_d;
  logic                tx_we_q,    tx_we_d;
  logic [7:0]          tx_data_q,  tx_data_d;
  logic [NUM_REQ-1:0]  req_ack_q,  req_ack_d;

  logic       arb_valid;
  logic [1:0] arb_id;

  rr_arbiter4 u_rr (
    .req     (req_valid[3:0]),
    .pointer (ptr_q),
    .valid   (arb_valid),
    .id      (arb_id)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    busy_d     = busy_q;
    tx_data_d  = tx_data_q;
    tx_we_d    = 1'b0;
    req_ack_d  = '0;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          // The word is copied here so later req_data/req_valid changes
          // cannot disturb the frame in flight.
          word_d            = req_data[{arb_id, 5'b00000} +: 32];
          id_d              = arb_id;
          ptr_d             = arb_id + 2'd1;
          req_ack_d[arb_id] = 1'b1;
          busy_d            = 1'b1;
          byte_cnt_d        = 3'd0;
          state_d           = ST_SEND;
        end
      end
      ST_SEND: begin
        // tx_we is registered, so it only ever follows a cycle in which the
        // UART was seen idle; leaving SEND immediately prevents a second pulse.
        if (!tx_busy) begin
          tx_we_d   = 1'b1;
          tx_data_d = frame_byte(HDR_NIBBLE, id_q, word_q, byte_cnt_q);
          state_d   = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (tx_busy) begin
          state_d = ST_WAIT_LO;
        end
      end
      ST_WAIT_LO: begin
        if (!tx_busy) begin
          if (byte_cnt_q == 3'(FRAME_BYTES - 1)) begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
            state_d    = ST_SEND;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 2'd0;
      id_q       <= 2'd0;
      word_q     <= 32'd0;
      byte_cnt_q <= 3'd0;
      busy_q     <= 1'b0;
      tx_we_q    <= 1'b0;
      tx_data_q  <= 8'd0;
      req_ack_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
      busy_q     <= busy_d;
      tx_we_q    <= tx_we_d;
      tx_data_q  <= tx_data_d;
      req_ack_q  <= req_ack_d;
    end
  end

  assign req_ack  = req_ack_q;
  assign tx_we    = tx_we_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign grant_id = id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed scenarios for uart_tx_arbiter with a behavioural UART, a
// requester model that drops its flag on ack, and a scoreboard of expected
// bytes and acks checked by an independent monitor.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ack;
  logic         tx_we;
  logic [7:0]   tx_data;
  logic         tx_busy;
  logic         busy;
  logic [1:0]   grant_id;

  int vectors     = 0;
  int miscompares = 0;

  int         issued [4];
  int         acked  [4];
  logic [3:0] pulse;
  logic       force_busy;
  int         ucnt   = 0;
  int         we_cnt = 0;
  logic       prev_we = 1'b0;

  logic [7:0] exp_bytes[$];
  int         exp_acks[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .HDR_NIBBLE(4'hA)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .tx_we     (tx_we),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  // Requester i holds its flag while it has more issues than acks.
  always_comb begin
    req_valid = pulse;
    for (int i = 0; i < 4; i++)
      if (issued[i] != acked[i]) req_valid[i] = 1'b1;
  end

  // Behavioural UART: busy for 4 cycles starting the cycle after tx_we.
  always @(posedge clk) begin
    if (tx_we && !tx_busy) ucnt <= 4;
    else if (ucnt > 0)     ucnt <= ucnt - 1;
  end
  assign tx_busy = (ucnt > 0) || force_busy;

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (tx_we) begin
      we_cnt++;
      vectors++;
      if (exp_bytes.size() == 0) begin
        miscompares++;
        $display("FAIL tx_byte: unexpected tx_we with data %02h, no byte expected", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_bytes.pop_front();
        if (tx_data !== e) begin
          miscompares++;
          $display("FAIL tx_byte: got %02h expected %02h", tx_data, e);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (req_ack[i]) begin
        acked[i]++;
        vectors++;
        if (exp_acks.size() == 0) begin
          miscompares++;
          $display("FAIL req_ack: unexpected ack for requester %0d", i);
        end else begin
          int ea;
          ea = exp_acks.pop_front();
          if (i != ea) begin
            miscompares++;
            $display("FAIL req_ack: got ack %0d expected %0d", i, ea);
          end
        end
      end
    end
    if (tx_we && prev_we) begin
      miscompares++;
      $display("FAIL tx_we_consecutive: tx_we high on two consecutive cycles");
    end
    if (tx_we && tx_busy) begin
      miscompares++;
      $display("FAIL tx_we_busy: tx_we=1 while tx_busy=1");
    end
    if (!$onehot0(req_ack)) begin
      miscompares++;
      $display("FAIL ack_onehot: req_ack=%b not one-hot", req_ack);
    end
    prev_we = tx_we;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Push the expected frame (first nbytes bytes) and ack, then raise the flag.
  task automatic issue(input int id, input logic [31:0] w, input int nbytes);
    logic [7:0] fb [5];
    fb[0] = {4'hA, 2'b00, 2'(id)};
    fb[1] = w[31:24];
    fb[2] = w[23:16];
    fb[3] = w[15:8];
    fb[4] = w[7:0];
    req_data[32*id +: 32] = w;
    for (int b = 0; b < nbytes; b++) exp_bytes.push_back(fb[b]);
    exp_acks.push_back(id);
    issued[id]++;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while ((exp_bytes.size() != 0 || exp_acks.size() != 0 || busy || tx_busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= 2000) begin
      miscompares++;
      $display("FAIL %s_timeout: got %0d bytes pending expected 0", name, exp_bytes.size());
    end
  endtask

  task automatic wait_we(input string name, input int target);
    int n = 0;
    while (we_cnt < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= 500) begin
      miscompares++;
      $display("FAIL %s_timeout: got we_cnt %0d expected %0d", name, we_cnt, target);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation time limit expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int n;
    rst_n      = 1'b0;
    pulse      = 4'b0;
    force_busy = 1'b0;
    req_data   = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_tx_we",    32'(tx_we),    0);
    chk("rst_tx_data",  32'(tx_data),  0);
    chk("rst_req_ack",  32'(req_ack),  0);
    chk("rst_busy",     32'(busy),     0);
    chk("rst_grant_id", 32'(grant_id), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single requester 2, word DEADBEEF; data changed after capture must not matter
    base = we_cnt;
    issue(2, 32'hDEADBEEF, 5);
    @(negedge clk);
    @(negedge clk);
    req_data[64 +: 32] = 32'h01234567;
    wait_idle("single");
    chk("single_bytes", 32'(we_cnt - base), 5);
    chk("single_busy",  32'(busy), 0);
    chk("single_gid",   32'(grant_id), 2);

    // Fresh reset, all four requesters: order 0,1,2,3 then 0 again
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) issue(i, 32'(i), 5);
    wait_idle("rr_round1");
    chk("rr_gid_last", 32'(grant_id), 3);
    for (int i = 0; i < 4; i++) issue(i, 32'(i), 5);
    wait_idle("rr_round2");
    for (int i = 0; i < 4; i++) chk("rr_ack_count", 32'(acked[i]), 32'(issued[i]));

    // UART held busy at SEND entry for 20 cycles
    force_busy = 1'b1;
    base = we_cnt;
    issue(1, 32'h12345678, 5);
    repeat (20) @(negedge clk);
    chk("hold_no_we", 32'(we_cnt - base), 0);
    chk("hold_busy",  32'(busy), 1);
    force_busy = 1'b0;
    wait_we("hold_release", base + 1);
    chk("hold_one_pulse", 32'(we_cnt - base), 1);
    wait_idle("hold");

    // Reset during 3rd byte WAIT_LO with requester 1 pending
    base = we_cnt;
    issue(0, 32'hCAFEF00D, 3);
    wait_we("abort_b1", base + 1);
    issue(1, 32'h0BADC0DE, 5);
    wait_we("abort_b3", base + 3);
    n = 0;
    while (!tx_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_tx_we", 32'(tx_we), 0);
    chk("abort_busy",  32'(busy),  0);
    chk("abort_ack",   32'(req_ack), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_idle("abort_resume");
    chk("abort_gid", 32'(grant_id), 1);

    // Requester 3 pulses for one cycle mid-frame: ignored
    base = we_cnt;
    issue(2, 32'h55AA33CC, 5);
    wait_we("pulse_b1", base + 1);
    pulse[3] = 1'b1;
    @(negedge clk);
    pulse[3] = 1'b0;
    wait_idle("pulse");
    repeat (10) @(negedge clk);
    chk("pulse_no_ack3", 32'(acked[3]), 32'(issued[3]));
    chk("pulse_bytes",   32'(we_cnt - base), 5);
    chk("pulse_busy",    32'(busy), 0);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
